map_row_fetcher: RTL and testbench

Supplies real map cell contents to the map overlay, which until now has drawn only gridlines and player markers. During horizontal blanking before each new map row, it reads one row of 2-bit cell values from the map store over a req/ack handshake into a back buffer. At the next line start it swaps that buffer to the front. During the visible line it outputs the cell value under the current beam position, registered.

---
 rtl/map_row_fetcher_if.sv | 28 ++
 rtl/map_row_fetcher.sv | 179 +++++++++++++++++
 tb/tb_map_row_fetcher.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_row_fetcher_if.sv
// Request/acknowledge bus between the map row fetcher (master) and the map store (slave).
// The map store presents map_val in the same cycle it raises map_ack.
interface map_row_fetcher_if #(
  parameter int MAP_WIDTH_BITS  = 4,
  parameter int MAP_HEIGHT_BITS = 4
);
  logic                       map_req;
  logic [MAP_HEIGHT_BITS-1:0] map_row;
  logic [MAP_WIDTH_BITS-1:0]  map_col;
  logic                       map_ack;
  logic [1:0]                 map_val;

  modport master (
    output map_req,
    output map_row,
    output map_col,
    input  map_ack,
    input  map_val
  );

  modport slave (
    input  map_req,
    input  map_row,
    input  map_col,
    output map_ack,
    output map_val
  );
endinterface

// File: rtl/map_row_fetcher.sv
// Fetches one map row per cell row into a back buffer during horizontal blanking,
// swaps it to the front at line start, and outputs the cell value under the beam.
module map_row_fetcher #(
  parameter int H_VIEW          = 640,
  parameter int V_TOTAL         = 525,
  parameter int MAP_WIDTH_BITS  = 4,
  parameter int MAP_HEIGHT_BITS = 4,
  parameter int MAP_SCALE       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  map_row_fetcher_if.master        bus,
  output logic [1:0]               cell_val,
  output logic                     fetch_busy,
  output logic                     fetch_overrun
);

  localparam int MAP_COLS = 1 << MAP_WIDTH_BITS;
  localparam int MAP_ROWS = 1 << MAP_HEIGHT_BITS;
  localparam logic [9:0] AREA_W = 10'(MAP_COLS << MAP_SCALE);
  localparam logic [9:0] AREA_H = 10'(MAP_ROWS << MAP_SCALE);
  localparam logic [9:0] H_TRIG = 10'(H_VIEW);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [MAP_WIDTH_BITS-1:0] COL_LAST = {MAP_WIDTH_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  logic [9:0]                 next_vpos;
  logic                       trigger;
  logic                       line_start;
  logic                       fetch_start;
  logic                       fetch_abort;
  logic                       fetch_end;
  logic                       col_wr;
  logic                       swap;

  logic                       req;
  logic [MAP_HEIGHT_BITS-1:0] row;
  logic [MAP_WIDTH_BITS-1:0]  col;
  logic [MAP_COLS-1:0][1:0]   front;
  logic [MAP_COLS-1:0][1:0]   back;
  logic                       overrun;

  function automatic logic in_area(input logic [9:0] h, input logic [9:0] v);
    return (h < AREA_W) && (v < AREA_H);
  endfunction

  // Beam-derived strobes: fetch trigger for the upcoming line and line start.
  always_comb begin
    next_vpos  = (vpos == V_LAST) ? 10'd0 : (vpos + 10'd1);
    trigger    = (hpos == H_TRIG) && (next_vpos < AREA_H) &&
                 (next_vpos[MAP_SCALE-1:0] == {MAP_SCALE{1'b0}});
    line_start = (hpos == 10'd0);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and per-cycle datapath strobes.
  always_comb begin
    state_next  = state;
    fetch_start = 1'b0;
    fetch_abort = 1'b0;
    fetch_end   = 1'b0;
    col_wr      = 1'b0;
    swap        = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          fetch_start = 1'b1;
          state_next  = FETCH;
        end else begin
          state_next  = IDLE;
        end
      end
      FETCH: begin
        // Line start wins over a coincident ack: the partial row is discarded.
        if (line_start) begin
          fetch_abort = 1'b1;
          state_next  = IDLE;
        end else if (bus.map_ack) begin
          col_wr = 1'b1;
          if (col == COL_LAST) begin
            fetch_end  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = FETCH;
          end
        end else begin
          state_next = FETCH;
        end
      end
      DONE: begin
        if (line_start) begin
          swap       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request bus registers; row/col hold their last values while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req <= 1'b0;
      row <= {MAP_HEIGHT_BITS{1'b0}};
      col <= {MAP_WIDTH_BITS{1'b0}};
    end else if (fetch_start) begin
      req <= 1'b1;
      row <= next_vpos[MAP_SCALE+MAP_HEIGHT_BITS-1:MAP_SCALE];
      col <= {MAP_WIDTH_BITS{1'b0}};
    end else if (fetch_abort || fetch_end) begin
      req <= 1'b0;
    end else if (col_wr) begin
      col <= col + MAP_WIDTH_BITS'(1);
    end else begin
      req <= req;
    end
  end

  // Back buffer capture and whole-row swap into the front buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      back  <= '{default: 2'b00};
      front <= '{default: 2'b00};
    end else begin
      if (col_wr) begin
        back[col] <= bus.map_val;
      end
      if (swap) begin
        front <= back;
      end
    end
  end

  // Sticky overrun flag and registered cell lookup under the beam.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun  <= 1'b0;
      cell_val <= 2'b00;
    end else begin
      if (fetch_abort) begin
        overrun <= 1'b1;
      end
      if (in_area(hpos, vpos)) begin
        cell_val <= front[hpos[MAP_SCALE+MAP_WIDTH_BITS-1:MAP_SCALE]];
      end else begin
        cell_val <= 2'b00;
      end
    end
  end

  assign bus.map_req   = req;
  assign bus.map_row   = row;
  assign bus.map_col   = col;
  assign fetch_busy    = (state != IDLE);
  assign fetch_overrun = overrun;

endmodule

// File: tb/tb_map_row_fetcher.sv
// Bench for map_row_fetcher: map store model with configurable ack delay, a row-level
// reference model checked every cycle, and directed literal checks on key scenarios.
module tb_map_row_fetcher;

  localparam int NCOL = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic [1:0] cell_val;
  logic       fetch_busy;
  logic       fetch_overrun;

  map_row_fetcher_if #(.MAP_WIDTH_BITS(4), .MAP_HEIGHT_BITS(4)) bus ();

  map_row_fetcher #(
    .H_VIEW(640), .V_TOTAL(525), .MAP_WIDTH_BITS(4), .MAP_HEIGHT_BITS(4), .MAP_SCALE(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hpos(hpos),
    .vpos(vpos),
    .bus(bus),
    .cell_val(cell_val),
    .fetch_busy(fetch_busy),
    .fetch_overrun(fetch_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int mem [16][16];
  int store_mode  = 0;   // 0: fixed delay, 1: random delay, 2: never ack
  int fixed_delay = 0;
  int req_hi_cycles = 0;
  int line_cell [130];

  // Reference model: which complete map row is on screen, and fetch progress in acks.
  int m_front_row = -1;
  int m_fetching  = 0;
  int m_ready     = 0;
  int m_acks      = 0;
  int m_row       = 0;
  int m_col       = 0;
  int m_over      = 0;
  int m_cell      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int next_line(input int v);
    return (v == 524) ? 0 : v + 1;
  endfunction

  function automatic int is_trigger(input int h, input int v);
    int nv;
    nv = next_line(v);
    return ((h == 640) && (nv < 128) && (nv % 8 == 0)) ? 1 : 0;
  endfunction

  function automatic int model_cell(input int h, input int v);
    if (h >= 128 || v >= 128 || m_front_row < 0) return 0;
    return mem[m_front_row][h / 8];
  endfunction

  function automatic int pick_delay();
    if (store_mode == 0) return fixed_delay;
    if (store_mode == 1) return int'($urandom_range(0, 5));
    return 1000000;
  endfunction

  // Map store: acks the current request after the chosen number of wait cycles.
  initial begin
    int wait_cnt;
    int cur_delay;
    bus.map_ack = 1'b0;
    bus.map_val = 2'b00;
    wait_cnt  = 0;
    cur_delay = 0;
    forever begin
      @(negedge clk);
      if (bus.map_req === 1'b1 && reset === 1'b0) begin
        if (wait_cnt >= cur_delay) begin
          bus.map_ack = 1'b1;
          bus.map_val = 2'(mem[bus.map_row][bus.map_col]);
          wait_cnt    = 0;
          cur_delay   = pick_delay();
        end else begin
          bus.map_ack = 1'b0;
          bus.map_val = 2'($urandom);
          wait_cnt++;
        end
      end else begin
        bus.map_ack = 1'b0;
        bus.map_val = 2'($urandom);
        wait_cnt    = 0;
        cur_delay   = pick_delay();
      end
    end
  end

  // Model step at every active edge, then compare all outputs just after it.
  initial begin
    int s_h;
    int s_v;
    forever begin
      @(posedge clk);
      s_h = int'(hpos);
      s_v = int'(vpos);
      if (reset === 1'b1) begin
        m_front_row = -1; m_fetching = 0; m_ready = 0; m_acks = 0;
        m_row = 0; m_col = 0; m_over = 0; m_cell = 0;
      end else begin
        m_cell = model_cell(s_h, s_v);
        if (m_fetching != 0) begin
          if (s_h == 0) begin
            m_fetching = 0;
            m_over     = 1;
          end else if (bus.map_ack === 1'b1) begin
            m_acks++;
            if (m_acks == NCOL) begin
              m_fetching = 0;
              m_ready    = 1;
            end else begin
              m_col = m_acks;
            end
          end
        end else if (m_ready != 0) begin
          if (s_h == 0) begin
            m_ready     = 0;
            m_front_row = m_row;
          end
        end else if (is_trigger(s_h, s_v) != 0) begin
          m_fetching = 1;
          m_acks     = 0;
          m_row      = next_line(s_v) / 8;
          m_col      = 0;
        end
      end
      #1;
      if (bus.map_req === 1'b1) req_hi_cycles++;
      check("map_req",       int'(bus.map_req),   m_fetching);
      check("map_row",       int'(bus.map_row),   m_row);
      check("map_col",       int'(bus.map_col),   m_col);
      check("cell_val",      int'(cell_val),      m_cell);
      check("fetch_busy",    int'(fetch_busy),    (m_fetching != 0 || m_ready != 0) ? 1 : 0);
      check("fetch_overrun", int'(fetch_overrun), m_over);
    end
  end

  task automatic cycle(input int h, input int v);
    @(negedge clk);
    hpos = 10'(h);
    vpos = 10'(v);
    @(posedge clk);
    #2;
  endtask

  task automatic run_visible(input int v);
    for (int h = 0; h < 130; h++) begin
      cycle(h, v);
      line_cell[h] = int'(cell_val);
    end
  endtask

  task automatic run_blank(input int v, input int h_first, input int h_last);
    for (int h = h_first; h <= h_last; h++) cycle(h, v);
  endtask

  task automatic run_line(input int v, input int h_last);
    run_visible(v);
    run_blank(v, 636, h_last);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    hpos  = 10'd0;
    vpos  = 10'd0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mem[r][c] = (r == 1) ? (c & 3) : ((c ^ r) & 3);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Ack tied high: row 1 fetched in 16 request cycles, shown on line 8.
    store_mode = 0; fixed_delay = 0;
    run_line(6, 799);
    req_hi_cycles = 0;
    run_line(7, 799);
    check("fetch_cycles_ack_high", req_hi_cycles, 16);
    run_line(8, 799);
    for (int h = 40; h <= 47; h++) check("line8_cell_col5", line_cell[h], 1);
    check("line8_cell_col2", line_cell[20], 2);

    // Ack delayed 3 cycles per request: 64 request cycles, row 2 on line 16.
    fixed_delay = 3;
    req_hi_cycles = 0;
    run_line(15, 799);
    check("fetch_cycles_delay3", req_hi_cycles, 64);
    run_line(16, 799);
    check("line16_cell_col5", line_cell[44], 3);
    check("line16_cell_col0", line_cell[3], 2);

    // Overrun: ack withheld, line start aborts, stale row 2 stays visible.
    store_mode = 2;
    run_line(23, 799);
    run_line(24, 799);
    check("overrun_flag", int'(fetch_overrun), 1);
    check("overrun_req_low", int'(bus.map_req), 0);
    check("overrun_idle", int'(fetch_busy), 0);
    check("line24_stale_col5", line_cell[44], 3);

    // Wrap at the last line fetches row 0; lines 127 and 3 do not trigger.
    store_mode = 0; fixed_delay = 0;
    run_visible(524);
    run_blank(524, 636, 645);
    check("wrap_req", int'(bus.map_req), 1);
    check("wrap_row", int'(bus.map_row), 0);
    run_blank(524, 646, 799);
    run_visible(0);
    check("line0_cell_col5", line_cell[40], 1);
    check("outside_h128", line_cell[128], 0);
    check("outside_h129", line_cell[129], 0);
    run_visible(127);
    run_blank(127, 636, 650);
    check("no_trigger_127", int'(fetch_busy), 0);
    run_visible(3);
    run_blank(3, 636, 650);
    check("no_trigger_3", int'(fetch_busy), 0);
    run_line(130, 799);
    check("outside_v130", line_cell[40], 0);

    // Asynchronous reset in the middle of a fetch.
    fixed_delay = 3;
    run_visible(31);
    run_blank(31, 636, 660);
    check("pre_reset_busy", int'(fetch_busy), 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_req", int'(bus.map_req), 0);
    check("async_rst_col", int'(bus.map_col), 0);
    check("async_rst_row", int'(bus.map_row), 0);
    check("async_rst_busy", int'(fetch_busy), 0);
    check("async_rst_overrun", int'(fetch_overrun), 0);
    check("async_rst_cell", int'(cell_val), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_line(40, 799);
    check("post_reset_cell", line_cell[40], 0);

    // Randomized map contents, ack delays and blanking lengths.
    sync_reset();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mem[r][c] = int'($urandom_range(0, 3));
    store_mode = 1;
    for (int i = 0; i < 140; i++) begin
      int v;
      int h_last;
      v = (520 + i) % 525;
      h_last = ($urandom_range(0, 3) == 0) ? int'($urandom_range(660, 720)) : 799;
      run_line(v, h_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
